// File: rtl/bsg_wormhole_wrr_packet_arbiter_pkg.sv
// Shared types for the weighted round-robin wormhole packet arbiter.
// Holds the arbiter state enum and an index-width helper.
package bsg_wormhole_wrr_packet_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wh_state_e;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_wormhole_wrr_packet_arbiter_if.sv
// Handshake bundle between the input FIFO heads, the arbiter
// and the concentrated output link.
interface bsg_wormhole_wrr_packet_arbiter_if #(
  parameter int num_in_p       = 2,
  parameter int len_width_p    = 4,
  parameter int weight_width_p = 4
);
  logic [num_in_p-1:0]                v_i;
  logic [num_in_p*len_width_p-1:0]    len_i;
  logic [num_in_p*weight_width_p-1:0] weights_i;
  logic                               ready_and_i;
  logic                               v_o;
  logic [num_in_p-1:0]                sel_one_hot_o;
  logic [num_in_p-1:0]                yumi_o;

  modport master (
    output v_i, len_i, weights_i, ready_and_i,
    input  v_o, sel_one_hot_o, yumi_o
  );

  modport slave (
    input  v_i, len_i, weights_i, ready_and_i,
    output v_o, sel_one_hot_o, yumi_o
  );
endinterface

// File: rtl/bsg_wormhole_wrr_rr_pick.sv
// Rotating-priority picker: first requester at or after the
// pointer, wrapping; one-hot grant plus any-grant flag.
module bsg_wormhole_wrr_rr_pick #(
  parameter int num_in_p = 2,
  parameter int idx_w_p  = 1
) (
  input  logic [num_in_p-1:0] req_i,
  input  logic [idx_w_p-1:0]  ptr_i,
  output logic [num_in_p-1:0] grant_o,
  output logic                v_o
);
  int k;

  always_comb begin
    grant_o = '0;
    v_o     = 1'b0;
    k       = 0;
    for (int i = 0; i < num_in_p; i++) begin
      k = (int'(ptr_i) + i) % num_in_p;
      if (!v_o && req_i[idx_w_p'(k)]) begin
        grant_o[idx_w_p'(k)] = 1'b1;
        v_o                  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bsg_wormhole_wrr_packet_arbiter.sv
// Packet-granular weighted round-robin arbiter: locks one input
// for a whole wormhole packet and enforces per-input quotas.
module bsg_wormhole_wrr_packet_arbiter
  import bsg_wormhole_wrr_packet_arbiter_pkg::*;
#(
  parameter int num_in_p        = 2,
  parameter int len_width_p     = 4,
  parameter int weight_width_p  = 4,
  parameter int hold_on_valid_p = 0
) (
  input logic clk_i,
  input logic reset_i,
  bsg_wormhole_wrr_packet_arbiter_if.slave io
);
  localparam int idx_w = idx_width(num_in_p);

  wh_state_e                 state_q;
  logic [idx_w-1:0]          ptr_q;
  logic [idx_w-1:0]          owner_q;
  logic [len_width_p-1:0]    cnt_q;
  logic [weight_width_p-1:0] credit_q [num_in_p];
  logic                      hold_q;
  logic [num_in_p-1:0]       hold_sel_q;

  logic [num_in_p-1:0]    elig;
  logic [num_in_p-1:0]    pick;
  logic                   pick_v;
  logic [num_in_p-1:0]    sel;
  logic                   v;
  logic                   refill;
  logic                   xfer;
  logic [idx_w-1:0]       s_idx;
  logic [idx_w-1:0]       ptr_nxt;
  logic [len_width_p-1:0] s_len;

  always_comb begin
    elig = '0;
    for (int i = 0; i < num_in_p; i++)
      elig[i] = io.v_i[i] & (credit_q[i] != '0);
  end

  bsg_wormhole_wrr_rr_pick #(
    .num_in_p(num_in_p),
    .idx_w_p (idx_w)
  ) pick_u (
    .req_i  (elig),
    .ptr_i  (ptr_q),
    .grant_o(pick),
    .v_o    (pick_v)
  );

  // A held offer wins over fresh arbitration until it is accepted
  always_comb begin
    sel    = '0;
    v      = 1'b0;
    refill = 1'b0;
    if (reset_i) begin
      sel = '0;
    end else if (state_q == LOCKED) begin
      sel[owner_q] = 1'b1;
      v            = io.v_i[owner_q];
    end else if (hold_q) begin
      sel = hold_sel_q;
      v   = 1'b1;
    end else if (pick_v) begin
      sel = pick;
      v   = 1'b1;
    end else begin
      refill = |io.v_i;
    end
  end

  always_comb begin
    s_idx = '0;
    s_len = '0;
    for (int i = 0; i < num_in_p; i++) begin
      if (sel[i]) begin
        s_idx = idx_w'(i);
        s_len = io.len_i[i*len_width_p +: len_width_p];
      end
    end
  end

  assign ptr_nxt = (s_idx == idx_w'(num_in_p - 1)) ? '0 : s_idx + 1'b1;
  assign xfer    = v & io.ready_and_i;

  assign io.v_o           = v;
  assign io.sel_one_hot_o = sel;
  assign io.yumi_o        = sel & {num_in_p{xfer}};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      hold_sel_q <= '0;
      for (int i = 0; i < num_in_p; i++)
        credit_q[i] <= '0;
    end else begin
      // Zero weights reload as one so no input starves
      if (refill) begin
        for (int i = 0; i < num_in_p; i++)
          credit_q[i] <=
            (io.weights_i[i*weight_width_p +: weight_width_p] == '0)
            ? weight_width_p'(1)
            : io.weights_i[i*weight_width_p +: weight_width_p];
      end
      if (state_q == LOCKED) begin
        if (xfer) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == len_width_p'(1))
            state_q <= IDLE;
        end
      end else if (xfer) begin
        if (credit_q[s_idx] != '0)
          credit_q[s_idx] <= credit_q[s_idx] - 1'b1;
        ptr_q  <= ptr_nxt;
        hold_q <= 1'b0;
        if (s_len != '0) begin
          state_q <= LOCKED;
          owner_q <= s_idx;
          cnt_q   <= s_len;
        end
      end else if (v && (hold_on_valid_p != 0)) begin
        hold_q     <= 1'b1;
        hold_sel_q <= sel;
      end
    end
  end
endmodule
